// File: rtl/dpu_pkg.sv
// Shared types and helpers for the DPU compute tile: FSM states, accumulator
// default width, LeakyReLU shift and the int8 saturation helper.
package dpu_pkg;

  localparam int ACC_W_DEF   = 32;
  localparam int LEAKY_SHIFT = 3;
  localparam int SAT_W       = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_ACT,
    ST_REQ,
    ST_OUT,
    ST_DONE
  } state_e;

  // Callers sign-extend their wide requant result to SAT_W before the clamp.
  function automatic logic [7:0] sat_i8(input logic signed [SAT_W-1:0] v);
    if (v > 64'sd127)       return 8'h7f;
    else if (v < -64'sd128) return 8'h80;
    else                    return v[7:0];
  endfunction

endpackage

// File: rtl/dpu_postproc.sv
// Single-channel post-processing: stage 1 bias + activation, stage 2 requant
// + int8 saturate. LeakyReLU is built only when DPU_TILE_LEAKY_EN is defined.
module dpu_postproc
  import dpu_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             act_en_i,
  input  logic             req_en_i,
  input  logic [ACC_W-1:0] acc_i,
  input  logic [ACC_W-1:0] bias_i,
  input  logic [15:0]      scale_i,
  input  logic [4:0]       shift_i,
  output logic [7:0]       res_o
);

  localparam int PW = ACC_W + 16;

  logic [ACC_W-1:0]     sum;
  logic [ACC_W-1:0]     a_d, a_q;
  logic [7:0]           res_d, res_q;
  logic signed [PW-1:0] prod, rnd, shf;

  assign sum = acc_i + bias_i;

`ifdef DPU_TILE_LEAKY_EN
  assign a_d = ($signed(sum) > 0) ? sum : ($signed(sum) >>> LEAKY_SHIFT);
`else
  assign a_d = sum;
`endif

  // Operands widened explicitly so the product is exact in PW bits.
  assign prod = $signed({{16{a_q[ACC_W-1]}}, a_q}) *
                $signed({{ACC_W{scale_i[15]}}, scale_i});
  assign rnd  = (shift_i == 5'd0) ? '0 : (PW'(1) << (shift_i - 5'd1));
  assign shf  = (prod + rnd) >>> shift_i;

  assign res_d = sat_i8({{(SAT_W-PW){shf[PW-1]}}, shf});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q   <= '0;
      res_q <= '0;
    end else begin
      if (act_en_i) a_q   <= a_d;
      if (req_en_i) res_q <= res_d;
    end
  end

  assign res_o = res_q;

endmodule

// File: rtl/dpu_compute_tile.sv
// N_OC x N_IC int8 MAC tile: accumulates k_len beats per job, then runs bias,
// activation (LeakyReLU under DPU_TILE_LEAKY_EN) and requant per channel.
module dpu_compute_tile
  import dpu_pkg::*;
#(
  parameter int N_OC  = 4,
  parameter int N_IC  = 4,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [15:0]              k_len,
  input  logic [N_OC*ACC_W-1:0]    bias,
  input  logic [15:0]              scale,
  input  logic [4:0]               shift,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_IC*8-1:0]        in_act,
  input  logic [N_OC*N_IC*8-1:0]   in_wgt,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N_OC*8-1:0]        out_data,
  output logic                     busy,
  output logic                     done
);

  state_e                         state_q;
  logic [15:0]                    k_len_q, cnt_q;
  logic [15:0]                    scale_q;
  logic [4:0]                     shift_q;
  logic [N_OC-1:0][ACC_W-1:0]     acc_q, acc_d, bias_q;
  logic [N_OC-1:0][N_IC-1:0][15:0] prod;
  logic                           in_ready_q, out_valid_q, busy_q, done_q;
  logic                           act_en, req_en;

  for (genvar oc = 0; oc < N_OC; oc++) begin : g_mul_oc
    for (genvar ic = 0; ic < N_IC; ic++) begin : g_mul_ic
      localparam int WI = oc * N_IC + ic;
      assign prod[oc][ic] =
        $signed({{8{in_act[8*ic+7]}}, in_act[8*ic +: 8]}) *
        $signed({{8{in_wgt[8*WI+7]}}, in_wgt[8*WI +: 8]});
    end
  end

  // Products are sign-extended and the reduction wraps at ACC_W.
  always_comb begin
    acc_d = acc_q;
    for (int oc = 0; oc < N_OC; oc++) begin
      for (int ic = 0; ic < N_IC; ic++) begin
        acc_d[oc] = acc_d[oc] + {{(ACC_W-16){prod[oc][ic][15]}}, prod[oc][ic]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      k_len_q     <= '0;
      cnt_q       <= '0;
      scale_q     <= '0;
      shift_q     <= '0;
      acc_q       <= '0;
      bias_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            k_len_q <= k_len;
            scale_q <= scale;
            shift_q <= shift;
            bias_q  <= bias;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            if (k_len != 16'd0) begin
              state_q    <= ST_ACCUM;
              in_ready_q <= 1'b1;
            end else begin
              state_q <= ST_ACT;
            end
          end
        end
        ST_ACCUM: begin
          if (in_valid) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + 16'd1;
            if (cnt_q + 16'd1 == k_len_q) begin
              state_q    <= ST_ACT;
              in_ready_q <= 1'b0;
            end
          end
        end
        ST_ACT: state_q <= ST_REQ;
        ST_REQ: begin
          state_q     <= ST_OUT;
          out_valid_q <= 1'b1;
        end
        ST_OUT: begin
          if (out_ready) begin
            state_q     <= ST_DONE;
            out_valid_q <= 1'b0;
            done_q      <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign act_en = (state_q == ST_ACT);
  assign req_en = (state_q == ST_REQ);

  for (genvar oc = 0; oc < N_OC; oc++) begin : g_pp
    dpu_postproc #(.ACC_W(ACC_W)) u_pp (
      .clk      (clk),
      .rst_n    (rst_n),
      .act_en_i (act_en),
      .req_en_i (req_en),
      .acc_i    (acc_q[oc]),
      .bias_i   (bias_q[oc]),
      .scale_i  (scale_q),
      .shift_i  (shift_q),
      .res_o    (out_data[8*oc +: 8])
    );
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
